// File: rtl/blk_cb7879_if.sv
// Trace-capture bus between the OCI trace source, the packer and the trace sink.
// master: packer side (accepts atoms, presents frames and end status).
// slave:  environment side (supplies atoms, consumes frames).
interface blk_cb7879_if #(
  parameter int unsigned ATOM_W = 3,
  parameter int unsigned ATOMS  = 10,
  parameter int unsigned CNT_W  = 4
) ();

  logic                    atom_valid;
  logic [ATOM_W-1:0]       atom_data;
  logic                    atom_ready;
  logic                    end_req;
  logic [ATOM_W*ATOMS-1:0] dct_buffer;
  logic [CNT_W-1:0]        dct_count;
  logic                    dct_valid;
  logic                    dct_ready;
  logic                    test_ending;
  logic                    test_has_ended;

  modport master (
    input  atom_valid,
    input  atom_data,
    input  end_req,
    input  dct_ready,
    output atom_ready,
    output dct_buffer,
    output dct_count,
    output dct_valid,
    output test_ending,
    output test_has_ended
  );

  modport slave (
    output atom_valid,
    output atom_data,
    output end_req,
    output dct_ready,
    input  atom_ready,
    input  dct_buffer,
    input  dct_count,
    input  dct_valid,
    input  test_ending,
    input  test_has_ended
  );

endinterface

// File: rtl/blk_cb7879.sv
// OCI trace packer: packs ATOM_W-bit atoms into ATOMS-atom frames, hands frames
// to the sink with valid/ready, and runs the test_ending/test_has_ended sequence.
// All outputs are registered.
module blk_cb7879 #(
  parameter int unsigned ATOM_W = 3,
  parameter int unsigned ATOMS  = 10,
  parameter int unsigned CNT_W  = 4
) (
  input logic          clk,
  input logic          reset_n,
  blk_cb7879_if.master bus
);

  localparam int unsigned FrameW = ATOM_W * ATOMS;

  typedef enum logic [2:0] {StInit, StFill, StHold, StEnding, StEnded} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FrameW-1:0]  fill_q, fill_d;
  logic               end_pending_q, end_pending_d;
  logic               atom_ready_q, atom_ready_d;
  logic               dct_valid_q, dct_valid_d;
  logic [FrameW-1:0]  dct_buffer_q, dct_buffer_d;
  logic [CNT_W-1:0]   dct_count_q, dct_count_d;
  logic               test_ending_q, test_ending_d;
  logic               test_has_ended_q, test_has_ended_d;

  logic accept;
  logic handshake;

  assign accept    = bus.atom_valid & atom_ready_q;
  assign handshake = dct_valid_q & bus.dct_ready;

  // Next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    fill_d           = fill_q;
    end_pending_d    = end_pending_q;
    atom_ready_d     = atom_ready_q;
    dct_valid_d      = dct_valid_q;
    dct_buffer_d     = dct_buffer_q;
    dct_count_d      = dct_count_q;
    test_ending_d    = test_ending_q;
    test_has_ended_d = test_has_ended_q;

    unique case (state_q)
      StInit: begin
        state_d      = StFill;
        atom_ready_d = 1'b1;
      end

      StFill: begin
        if (accept) begin
          for (int i = 0; i < int'(ATOMS); i++) begin
            if (cnt_q == CNT_W'(i)) fill_d[i*ATOM_W +: ATOM_W] = bus.atom_data;
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
        // A filling accept wins over an end request; the end is remembered.
        if (cnt_d == CNT_W'(ATOMS)) begin
          state_d       = StHold;
          dct_valid_d   = 1'b1;
          dct_buffer_d  = fill_d;
          dct_count_d   = cnt_d;
          atom_ready_d  = 1'b0;
          end_pending_d = end_pending_q | bus.end_req;
        end else if (bus.end_req | end_pending_q) begin
          state_d       = StEnding;
          test_ending_d = 1'b1;
          atom_ready_d  = 1'b0;
        end else begin
          // After a handshake this re-opens the input one cycle late.
          atom_ready_d = 1'b1;
        end
      end

      StHold: begin
        end_pending_d = end_pending_q | bus.end_req;
        if (handshake) begin
          dct_valid_d  = 1'b0;
          dct_buffer_d = '0;
          dct_count_d  = '0;
          fill_d       = '0;
          cnt_d        = '0;
          if (end_pending_d) begin
            state_d       = StEnding;
            test_ending_d = 1'b1;
            end_pending_d = 1'b0;
          end else begin
            state_d = StFill;
          end
        end
      end

      StEnding: begin
        if (dct_valid_q) begin
          if (handshake) begin
            dct_valid_d      = 1'b0;
            dct_buffer_d     = '0;
            dct_count_d      = '0;
            state_d          = StEnded;
            test_has_ended_d = 1'b1;
          end
        end else if (cnt_q != '0) begin
          // Unfilled upper atoms of fill_q are already zero.
          dct_valid_d  = 1'b1;
          dct_buffer_d = fill_q;
          dct_count_d  = cnt_q;
          fill_d       = '0;
          cnt_d        = '0;
        end else begin
          state_d          = StEnded;
          test_has_ended_d = 1'b1;
        end
      end

      StEnded: begin
        atom_ready_d = 1'b0;
        dct_valid_d  = 1'b0;
      end

      default: state_d = StInit;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StInit;
      cnt_q            <= '0;
      fill_q           <= '0;
      end_pending_q    <= 1'b0;
      atom_ready_q     <= 1'b0;
      dct_valid_q      <= 1'b0;
      dct_buffer_q     <= '0;
      dct_count_q      <= '0;
      test_ending_q    <= 1'b0;
      test_has_ended_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      fill_q           <= fill_d;
      end_pending_q    <= end_pending_d;
      atom_ready_q     <= atom_ready_d;
      dct_valid_q      <= dct_valid_d;
      dct_buffer_q     <= dct_buffer_d;
      dct_count_q      <= dct_count_d;
      test_ending_q    <= test_ending_d;
      test_has_ended_q <= test_has_ended_d;
    end
  end

  assign bus.atom_ready     = atom_ready_q;
  assign bus.dct_valid      = dct_valid_q;
  assign bus.dct_buffer     = dct_buffer_q;
  assign bus.dct_count      = dct_count_q;
  assign bus.test_ending    = test_ending_q;
  assign bus.test_has_ended = test_has_ended_q;

endmodule

// File: tb/tb_blk_cb7879.sv
// Self-checking bench for blk_cb7879: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_blk_cb7879;

  localparam int unsigned ATOM_W = 3;
  localparam int unsigned ATOMS  = 10;
  localparam int unsigned CNT_W  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  blk_cb7879_if #(.ATOM_W(ATOM_W), .ATOMS(ATOMS), .CNT_W(CNT_W)) bus ();

  blk_cb7879 #(.ATOM_W(ATOM_W), .ATOMS(ATOMS), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected output values after each clock edge.
  bit          m_live, m_ready, m_valid, m_ending, m_ended, m_end_flag;
  logic [29:0] m_buf;
  int          m_cnt;
  logic [2:0]  m_q[$];   // atoms accepted into the frame being built

  function automatic logic [29:0] packed_q();
    logic [29:0] r = '0;
    foreach (m_q[i]) r = r | (30'(m_q[i]) << (3 * i));
    return r;
  endfunction

  task automatic model_reset();
    m_live = 0; m_ready = 0; m_valid = 0; m_ending = 0; m_ended = 0; m_end_flag = 0;
    m_buf = '0; m_cnt = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit av, input logic [2:0] ad, input bit er, input bit dr);
    bit acc;
    bit hs;
    acc = av && m_ready;
    hs  = m_valid && dr;
    if (!m_live) begin
      m_live = 1; m_ready = 1;
      return;
    end
    if (m_ended) return;
    if (m_valid) begin
      if (er) m_end_flag = 1;
      if (hs) begin
        m_valid = 0; m_buf = '0; m_cnt = 0;
        if (m_ending) m_ended = 1;
        else if (m_end_flag) m_ending = 1;
      end
      return;
    end
    if (m_ending) begin
      if (m_q.size() == 0) m_ended = 1;
      else begin
        m_valid = 1; m_buf = packed_q(); m_cnt = m_q.size(); m_q.delete();
      end
      return;
    end
    if (acc) m_q.push_back(ad);
    if (m_q.size() == int'(ATOMS)) begin
      m_valid = 1; m_buf = packed_q(); m_cnt = int'(ATOMS); m_q.delete(); m_ready = 0;
      if (er) m_end_flag = 1;
    end else if (er) begin
      m_ending = 1; m_ready = 0;
    end else begin
      m_ready = 1;
    end
  endtask

  task automatic check_outputs();
    check_eq("atom_ready",     32'(bus.atom_ready),     32'(m_ready));
    check_eq("dct_valid",      32'(bus.dct_valid),      32'(m_valid));
    check_eq("dct_buffer",     32'(bus.dct_buffer),     32'(m_buf));
    check_eq("dct_count",      32'(bus.dct_count),      32'(m_cnt));
    check_eq("test_ending",    32'(bus.test_ending),    32'(m_ending));
    check_eq("test_has_ended", 32'(bus.test_has_ended), 32'(m_ended));
  endtask

  task automatic step(input bit av, input logic [2:0] ad, input bit er, input bit dr);
    bus.atom_valid = av;
    bus.atom_data  = ad;
    bus.end_req    = er;
    bus.dct_ready  = dr;
    @(posedge clk);
    model_step(av, ad, er, dr);
    #1;
    check_outputs();
  endtask

  // Asserts reset away from a clock edge, checks the immediate clear, releases on negedge.
  task automatic do_reset();
    bus.atom_valid = 1'b0;
    bus.atom_data  = '0;
    bus.end_req    = 1'b0;
    bus.dct_ready  = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.atom_valid = 1'b0;
    bus.atom_data  = '0;
    bus.end_req    = 1'b0;
    bus.dct_ready  = 1'b0;
    #2;
    do_reset();
    repeat (3) step(0, 3'd0, 0, 0);

    // Back-to-back full frame, sink always ready.
    for (int i = 0; i < 10; i++) step(1, 3'(i % 8), 0, 1);
    check_eq("full_frame_const", 32'(bus.dct_buffer), 32'(30'o1076543210));
    check_eq("full_frame_count", 32'(bus.dct_count), 32'd10);
    repeat (4) step(0, 3'd0, 0, 1);

    // Full frame stalled by the sink for five cycles, atoms offered meanwhile.
    for (int i = 0; i < 10; i++) step(1, 3'(7 - (i % 8)), 0, 0);
    repeat (5) step(1, 3'd3, 0, 0);
    step(0, 3'd0, 0, 1);
    repeat (3) step(0, 3'd0, 0, 0);

    // Partial frame flushed by end_req; later atoms refused.
    step(1, 3'd5, 0, 0);
    step(1, 3'd6, 0, 0);
    step(1, 3'd7, 0, 0);
    step(0, 3'd0, 1, 0);
    step(0, 3'd0, 0, 0);
    check_eq("partial_frame", 32'(bus.dct_buffer), 32'(30'o765));
    check_eq("partial_count", 32'(bus.dct_count), 32'd3);
    step(0, 3'd0, 0, 1);
    check_eq("ended_after_partial", 32'(bus.test_has_ended), 32'd1);
    repeat (4) step(1, 3'd2, 0, 1);

    // end_req together with the 10th accept.
    do_reset();
    step(0, 3'd0, 0, 1);
    for (int i = 0; i < 9; i++) step(1, 3'(i), 0, 1);
    step(1, 3'd4, 1, 1);
    repeat (5) step(0, 3'd0, 0, 1);

    // Reset mid-fill, then a fresh frame.
    do_reset();
    step(0, 3'd0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 3'd7, 0, 0);
    do_reset();
    step(0, 3'd0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 3'(i + 1), 0, 1);
    repeat (3) step(0, 3'd0, 0, 1);

    // Reset mid-HOLD, then a fresh frame.
    for (int i = 0; i < 10; i++) step(1, 3'(i + 2), 0, 0);
    repeat (2) step(0, 3'd0, 0, 0);
    do_reset();
    step(0, 3'd0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 3'(i + 3), 0, 1);
    repeat (3) step(0, 3'd0, 0, 1);

    // Random traffic episodes.
    for (int e = 0; e < 6; e++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        step($urandom_range(0, 99) < 70, 3'($urandom), $urandom_range(0, 299) < 2,
             $urandom_range(0, 99) < 60);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
